// File: rtl/mem_probe_pkg.sv
// Shared types and constants for the data-memory probe scanner.
// State encodings are fixed 3-bit values so they are stable in waveforms.
package mem_probe_pkg;

  localparam int RD_LAT_MAX = 7;
  localparam int LAT_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_probe_scanner.sv
// Walks the data-memory probe over DEPTH words, emitting (addr,data) beats.
// Define MEM_PROBE_CSUM_EN to add an XOR checksum output of accepted beats.
module mem_probe_scanner
  import mem_probe_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 100,
  parameter int START_ADDR = 0,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_probe_addr,
  input  logic [DATA_W-1:0] i_probe_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
`ifdef MEM_PROBE_CSUM_EN
  output logic [DATA_W-1:0] o_csum,
`endif
  output logic [DATA_W-1:0] o_out_data
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [LAT_W-1:0] LAT_LAST =
    (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr_cnt;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  logic w_accept;
  logic w_hs;
  logic w_last;
  logic w_cap;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_hs     = (r_state == S_PRESENT) && i_out_ready;
  assign w_last   = (r_word_cnt == LAST_WORD);
  assign w_cap    = ((r_state == S_ISSUE) && (RD_LAT == 0)) ||
                    ((r_state == S_WAIT) && (r_lat_cnt == LAT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = (RD_LAT == 0) ? S_PRESENT : S_WAIT;
      end
      S_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (i_out_ready) begin
          w_next = w_last ? S_FIN : S_ISSUE;
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_out_valid = 1'b0;
    unique case (r_state)
      S_ISSUE,
      S_WAIT: begin
        o_busy = 1'b1;
      end
      S_PRESENT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
      end
      S_FIN: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // addr_cnt doubles as the probe address, so it idles on the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_cnt <= START;
      r_word_cnt <= '0;
      r_lat_cnt  <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr_cnt <= START;
        r_word_cnt <= '0;
      end else if (w_hs && !w_last) begin
        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (r_state == S_ISSUE) begin
        r_lat_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
      if (w_cap) begin
        r_out_addr <= r_addr_cnt;
        r_out_data <= i_probe_data;
      end
    end
  end

  assign o_probe_addr = r_addr_cnt;
  assign o_out_addr   = r_out_addr;
  assign o_out_data   = r_out_data;

`ifdef MEM_PROBE_CSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum ^ r_out_data;
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

// File: tb/tb_mem_probe_scanner.sv
// Bench for mem_probe_scanner: three instances with different latency,
// depth and start address, driven from a table of expected beats.
module tb_mem_probe_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  start;
  logic [2:0]  ready;
  logic        mode;
  wire  [2:0]  busy;
  wire  [2:0]  done;
  wire  [2:0]  valid;
  wire  [7:0]  paddr [3];
  wire  [31:0] pdata [3];
  wire  [7:0]  oaddr [3];
  wire  [31:0] odata [3];
`ifdef MEM_PROBE_CSUM_EN
  wire  [31:0] csum [3];
`endif

  mem_probe_scanner #(
    .DEPTH(4), .START_ADDR(0), .RD_LAT(1)
  ) u0 (
    .clk(clk), .rst(rst), .i_start(start[0]),
    .o_busy(busy[0]), .o_done(done[0]),
    .o_probe_addr(paddr[0]), .i_probe_data(pdata[0]),
    .o_out_valid(valid[0]), .i_out_ready(ready[0]),
    .o_out_addr(oaddr[0]),
`ifdef MEM_PROBE_CSUM_EN
    .o_csum(csum[0]),
`endif
    .o_out_data(odata[0])
  );

  mem_probe_scanner #(
    .DEPTH(3), .START_ADDR(8'h10), .RD_LAT(3)
  ) u1 (
    .clk(clk), .rst(rst), .i_start(start[1]),
    .o_busy(busy[1]), .o_done(done[1]),
    .o_probe_addr(paddr[1]), .i_probe_data(pdata[1]),
    .o_out_valid(valid[1]), .i_out_ready(ready[1]),
    .o_out_addr(oaddr[1]),
`ifdef MEM_PROBE_CSUM_EN
    .o_csum(csum[1]),
`endif
    .o_out_data(odata[1])
  );

  mem_probe_scanner #(
    .DEPTH(4), .START_ADDR(8'hFE), .RD_LAT(0)
  ) u2 (
    .clk(clk), .rst(rst), .i_start(start[2]),
    .o_busy(busy[2]), .o_done(done[2]),
    .o_probe_addr(paddr[2]), .i_probe_data(pdata[2]),
    .o_out_valid(valid[2]), .i_out_ready(ready[2]),
    .o_out_addr(oaddr[2]),
`ifdef MEM_PROBE_CSUM_EN
    .o_csum(csum[2]),
`endif
    .o_out_data(odata[2])
  );

  function automatic logic [31:0] f3(input logic [7:0] a);
    return {24'd0, a} * 32'd3;
  endfunction

  // probe models: u0 one-stage, u1 three-stage pipeline, u2 combinational
  logic [7:0] p1, q1, q2, q3;
  always @(posedge clk) begin
    p1 <= paddr[0];
    q1 <= paddr[1];
    q2 <= q1;
    q3 <= q2;
  end
  assign pdata[0] = mode ? (32'd1 << p1[1:0]) : f3(p1);
  assign pdata[1] = f3(q3);
  assign pdata[2] = f3(paddr[2]);

  int busy_n [3];
  int done_n [3];
  int hs_n   [3];
  initial begin
    for (int k = 0; k < 3; k++) begin
      busy_n[k] = 0;
      done_n[k] = 0;
      hs_n[k]   = 0;
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) busy_n[k]++;
      if (done[k]) done_n[k]++;
      if (valid[k] && ready[k]) hs_n[k]++;
    end
  end

  int nc = 0;
  int nf = 0;
  int bb [3];
  int bd [3];
  int bh [3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic kick(input int k);
    bb[k] = busy_n[k];
    bd[k] = done_n[k];
    bh[k] = hs_n[k];
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    chk($sformatf("u%0d busy after start", k), 32'(busy[k]), 32'd1);
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    while (!valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    nc++;
    if (!valid[k]) begin
      nf++;
      $display("FAIL u%0d valid timeout: got 0 want 1", k);
    end
  endtask

  task automatic beat(input int k, input int stall,
                      input logic [7:0] ea, input logic [31:0] ed);
    wait_valid(k);
    for (int s = 0; s < stall; s++) begin
      chk($sformatf("u%0d stall%0d valid", k, s), 32'(valid[k]), 32'd1);
      chk($sformatf("u%0d stall%0d addr", k, s), 32'(oaddr[k]), 32'(ea));
      chk($sformatf("u%0d stall%0d data", k, s), odata[k], ed);
      @(negedge clk);
    end
    chk($sformatf("u%0d beat addr", k), 32'(oaddr[k]), 32'(ea));
    chk($sformatf("u%0d beat data @%0h", k, ea), odata[k], ed);
    ready[k] = 1'b1;
    @(negedge clk);
    ready[k] = 1'b0;
  endtask

  task automatic fin(input int k, input int eb, input int n,
                     input logic [7:0] la);
    chk($sformatf("u%0d done in FIN", k), 32'(done[k]), 32'd1);
    chk($sformatf("u%0d busy in FIN", k), 32'(busy[k]), 32'd0);
    chk($sformatf("u%0d valid in FIN", k), 32'(valid[k]), 32'd0);
    @(negedge clk);
    chk($sformatf("u%0d done after FIN", k), 32'(done[k]), 32'd0);
    chk($sformatf("u%0d busy cycles", k), 32'(busy_n[k] - bb[k]), 32'(eb));
    chk($sformatf("u%0d done pulses", k), 32'(done_n[k] - bd[k]), 32'd1);
    chk($sformatf("u%0d handshakes", k), 32'(hs_n[k] - bh[k]), 32'(n));
    chk($sformatf("u%0d probe hold", k), 32'(paddr[k]), 32'(la));
  endtask

  typedef struct {
    int          k;
    bit          first;
    bit          last;
    bit          md;
    int          stall;
    logic [7:0]  a;
    logic [31:0] d;
    int          eb;
    int          n;
    logic [31:0] cs;
  } vec_t;

  vec_t tv [15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{0, 1, 0, 0, 0, 8'h00, 32'h0,   0,  0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 8'h01, 32'h3,   0,  0, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 8'h02, 32'h6,   0,  0, 0};
    tv[3]  = '{0, 0, 1, 0, 0, 8'h03, 32'h9,   12, 4, 32'hC};
    tv[4]  = '{1, 1, 0, 0, 0, 8'h10, 32'h30,  0,  0, 0};
    tv[5]  = '{1, 0, 0, 0, 0, 8'h11, 32'h33,  0,  0, 0};
    tv[6]  = '{1, 0, 1, 0, 0, 8'h12, 32'h36,  15, 3, 32'h35};
    tv[7]  = '{2, 1, 0, 0, 0, 8'hFE, 32'h2FA, 0,  0, 0};
    tv[8]  = '{2, 0, 0, 0, 5, 8'hFF, 32'h2FD, 0,  0, 0};
    tv[9]  = '{2, 0, 0, 0, 0, 8'h00, 32'h0,   0,  0, 0};
    tv[10] = '{2, 0, 1, 0, 0, 8'h01, 32'h3,   13, 4, 32'h4};
    tv[11] = '{0, 1, 0, 1, 0, 8'h00, 32'h1,   0,  0, 0};
    tv[12] = '{0, 0, 0, 1, 0, 8'h01, 32'h2,   0,  0, 0};
    tv[13] = '{0, 0, 0, 1, 0, 8'h02, 32'h4,   0,  0, 0};
    tv[14] = '{0, 0, 1, 1, 0, 8'h03, 32'h8,   12, 4, 32'hF};

    rst   = 1'b1;
    start = '0;
    ready = '0;
    mode  = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d rst busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("u%0d rst done", k), 32'(done[k]), 32'd0);
      chk($sformatf("u%0d rst valid", k), 32'(valid[k]), 32'd0);
      chk($sformatf("u%0d rst oaddr", k), 32'(oaddr[k]), 32'd0);
      chk($sformatf("u%0d rst odata", k), odata[k], 32'd0);
    end
    chk("u0 rst paddr", 32'(paddr[0]), 32'h00);
    chk("u1 rst paddr", 32'(paddr[1]), 32'h10);
    chk("u2 rst paddr", 32'(paddr[2]), 32'hFE);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // abort a scan while beat 1 is being presented
    kick(0);
    beat(0, 0, 8'h00, 32'h0);
    wait_valid(0);
    chk("u0 pre-abort paddr", 32'(paddr[0]), 32'h01);
    rst = 1'b1;
    #1;
    chk("u0 abort valid", 32'(valid[0]), 32'd0);
    chk("u0 abort busy", 32'(busy[0]), 32'd0);
    chk("u0 abort done", 32'(done[0]), 32'd0);
    chk("u0 abort paddr", 32'(paddr[0]), 32'h00);
`ifdef MEM_PROBE_CSUM_EN
    chk("u0 abort csum", csum[0], 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("u0 abort no done", 32'(done_n[0] - bd[0]), 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (tv[i].first) begin
        mode = tv[i].md;
        kick(tv[i].k);
      end
      beat(tv[i].k, tv[i].stall, tv[i].a, tv[i].d);
      if (tv[i].last) begin
`ifdef MEM_PROBE_CSUM_EN
        chk($sformatf("u%0d csum", tv[i].k), csum[tv[i].k], tv[i].cs);
`endif
        fin(tv[i].k, tv[i].eb, tv[i].n, tv[i].a);
      end
    end

    // starts while busy and in the done cycle must be ignored
    mode = 1'b0;
    ready[0] = 1'b1;
    kick(0);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    begin
      int n = 0;
      while (!done[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("u0 done reached", 32'(done[0]), 32'd1);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ready[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("u0 idle after ignored starts", 32'(busy[0]), 32'd0);
    chk("u0 single run done", 32'(done_n[0] - bd[0]), 32'd1);
    chk("u0 single run beats", 32'(hs_n[0] - bh[0]), 32'd4);
    chk("u0 single run busy", 32'(busy_n[0] - bb[0]), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
